// File: rtl/upe_pkg.sv
// Shared constants for the uncertainty propagation pipeline.
// Default operand width, result-width formula and sign encodings.
package upe_pkg;

  localparam int UPE_W_DEF = 16;
  localparam int UPE_GUARD = 2;

  localparam logic SGN_POS = 1'b0;
  localparam logic SGN_NEG = 1'b1;

  function automatic int upe_out_w(input int w);
    return 3 * w + UPE_GUARD;
  endfunction

endpackage

// File: rtl/upe_pipe_umul.sv
// Registered unsigned multiplier: p_o <= a_i * b_i when en_i.
// Ports: clk, rst_n, en_i, a_i[WA], b_i[WB], p_o[WA+WB].
module upe_pipe_umul #(
  parameter int WA = 16,
  parameter int WB = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic [WA-1:0]      a_i,
  input  logic [WB-1:0]      b_i,
  output logic [WA+WB-1:0]   p_o
);

  logic [WA+WB-1:0] p_d;
  logic [WA+WB-1:0] p_q;

  assign p_d = {{WB{1'b0}}, a_i} * {{WA{1'b0}}, b_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else if (en_i) begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/upe_pipe.sv
// 4-stage first-order uncertainty propagator:
//   var_z = dfdx^2*var_x + 2*dfdx*dfdy*covar_xy + dfdy^2*var_y.
// Ports: clk, rst_n, in_valid/in_ready, var_x, var_y, covar_xy,
//   dfdx, dfdy (W), out_valid/out_ready, var_z (OUT_W), neg_flag.
// Macro UPE_CLAMP_EN: negative sums drive var_z=0 (neg_flag still set).
module upe_pipe
  import upe_pkg::*;
#(
  parameter int W     = UPE_W_DEF,
  parameter int OUT_W = upe_out_w(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     var_x,
  input  logic [W-1:0]     var_y,
  input  logic [W-1:0]     covar_xy,
  input  logic [W-1:0]     dfdx,
  input  logic [W-1:0]     dfdy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] var_z,
  output logic             neg_flag
);

  // Global stall: every stage moves together, bubbles included.
  logic adv;

  logic v1_q, v2_q, v3_q, v4_q;

  // S1: operands as magnitude + sign.
  logic [W-1:0] vx1_q, vy1_q;
  logic [W-1:0] mc1_q, mdx1_q, mdy1_q;
  logic         sc1_q, sdx1_q, sdy1_q;
  logic [W-1:0] mc_d, mdx_d, mdy_d;

  // S2: gradient products (in umul), passthrough.
  logic [W-1:0]   vx2_q, vy2_q, mc2_q;
  logic           sxy2_q;
  logic [2*W-1:0] gxx, gyy, gxy;

  // S3: weighted terms (in umul), passthrough sign.
  logic           sxy3_q;
  logic [3*W-1:0] tx, ty, txy;

  // S4: final sum.
  logic [OUT_W-1:0] tx_e, ty_e, txy2_e;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] var_z_d, var_z_q;
  logic             neg_d, neg_q;

  assign adv      = !v4_q || out_ready;
  assign in_ready = adv;

  // Magnitude held at W bits unsigned, so -2^(W-1) maps to 2^(W-1).
  assign mc_d  = covar_xy[W-1] ? (~covar_xy + 1'b1) : covar_xy;
  assign mdx_d = dfdx[W-1] ? (~dfdx + 1'b1) : dfdx;
  assign mdy_d = dfdy[W-1] ? (~dfdy + 1'b1) : dfdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      v4_q <= 1'b0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      v4_q <= v3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx1_q  <= '0;
      vy1_q  <= '0;
      mc1_q  <= '0;
      mdx1_q <= '0;
      mdy1_q <= '0;
      sc1_q  <= SGN_POS;
      sdx1_q <= SGN_POS;
      sdy1_q <= SGN_POS;
    end else if (adv) begin
      vx1_q  <= var_x;
      vy1_q  <= var_y;
      mc1_q  <= mc_d;
      mdx1_q <= mdx_d;
      mdy1_q <= mdy_d;
      sc1_q  <= covar_xy[W-1];
      sdx1_q <= dfdx[W-1];
      sdy1_q <= dfdy[W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vx2_q  <= '0;
      vy2_q  <= '0;
      mc2_q  <= '0;
      sxy2_q <= SGN_POS;
      sxy3_q <= SGN_POS;
    end else if (adv) begin
      vx2_q  <= vx1_q;
      vy2_q  <= vy1_q;
      mc2_q  <= mc1_q;
      sxy2_q <= sc1_q ^ sdx1_q ^ sdy1_q;
      sxy3_q <= sxy2_q;
    end
  end

  upe_pipe_umul #(.WA(W), .WB(W)) u_gxx (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(mdx1_q), .b_i(mdx1_q), .p_o(gxx)
  );

  upe_pipe_umul #(.WA(W), .WB(W)) u_gyy (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(mdy1_q), .b_i(mdy1_q), .p_o(gyy)
  );

  upe_pipe_umul #(.WA(W), .WB(W)) u_gxy (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(mdx1_q), .b_i(mdy1_q), .p_o(gxy)
  );

  upe_pipe_umul #(.WA(W), .WB(2*W)) u_tx (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(vx2_q), .b_i(gxx), .p_o(tx)
  );

  upe_pipe_umul #(.WA(W), .WB(2*W)) u_ty (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(vy2_q), .b_i(gyy), .p_o(ty)
  );

  upe_pipe_umul #(.WA(W), .WB(2*W)) u_txy (
    .clk(clk), .rst_n(rst_n), .en_i(adv),
    .a_i(mc2_q), .b_i(gxy), .p_o(txy)
  );

  // Two guard bits above 3W cover the doubled cross term and the sign.
  always_comb begin
    tx_e    = {{(OUT_W-3*W){1'b0}}, tx};
    ty_e    = {{(OUT_W-3*W){1'b0}}, ty};
    txy2_e  = {{(OUT_W-3*W-1){1'b0}}, txy, 1'b0};
    sum     = sxy3_q ? (tx_e + ty_e - txy2_e)
                     : (tx_e + ty_e + txy2_e);
    neg_d   = sum[OUT_W-1];
`ifdef UPE_CLAMP_EN
    var_z_d = neg_d ? '0 : sum;
`else
    var_z_d = sum;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      var_z_q <= '0;
      neg_q   <= 1'b0;
    end else if (adv) begin
      var_z_q <= var_z_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid = v4_q;
  assign var_z     = var_z_q;
  assign neg_flag  = neg_q;

endmodule

// File: tb/tb_upe_pipe.sv
// Scoreboard bench for upe_pipe (W=16): directed vectors, stall,
// back-to-back streaming and mid-flight reset.
module tb_upe_pipe;

  localparam int W  = 16;
  localparam int OW = 3 * W + 2;

  typedef struct {
    logic [OW-1:0] z;
    logic          n;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  var_x, var_y, covar_xy, dfdx, dfdy;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] var_z;
  logic          neg_flag;

  exp_t          sb[$];
  exp_t          e_mon;
  int            n_cmp;
  int            n_bad;
  int            cyc;
  logic          hold_v;
  logic [OW-1:0] hold_z;
  logic          hold_n;

  upe_pipe #(.W(W), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .var_x(var_x), .var_y(var_y), .covar_xy(covar_xy),
    .dfdx(dfdx), .dfdy(dfdy),
    .out_valid(out_valid), .out_ready(out_ready),
    .var_z(var_z), .neg_flag(neg_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] vx, vy, c, dx, dy);
    exp_t   e;
    longint sdx, sdy, sc, z;
    sdx = longint'($signed(dx));
    sdy = longint'($signed(dy));
    sc  = longint'($signed(c));
    z   = sdx * sdx * longint'(vx) + 2 * sdx * sdy * sc
        + sdy * sdy * longint'(vy);
    e.n = (z < 0);
`ifdef UPE_CLAMP_EN
    if (z < 0) z = 0;
`endif
    e.z = z[OW-1:0];
    return e;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] vx, vy, c, dx, dy,
                      input exp_t e);
    int t;
    var_x    = vx;
    var_y    = vy;
    covar_xy = c;
    dfdx     = dx;
    dfdy     = dy;
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic send_rand();
    logic [W-1:0] vx, vy, c, dx, dy;
    vx = W'($urandom);
    vy = W'($urandom);
    c  = W'($urandom);
    dx = W'($urandom);
    dy = W'($urandom);
    send(vx, vy, c, dx, dy, model(vx, vy, c, dx, dy));
  endtask

  // Output side: pop on every handshake, hold-check while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          check("var_z", var_z, e_mon.z);
          check("neg_flag", neg_flag, e_mon.n);
        end
        hold_v = 1'b0;
      end else if (out_valid) begin
        check("in_ready_stall", in_ready, 0);
        if (hold_v) begin
          check("z_stable", var_z, hold_z);
          check("n_stable", neg_flag, hold_n);
        end
        hold_v = 1'b1;
        hold_z = var_z;
        hold_n = neg_flag;
      end else begin
        hold_v = 1'b0;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   lat;
    int   t0;
    int   run;
    int   t;
    logic [63:0] neg2;

    n_cmp     = 0;
    n_bad     = 0;
    cyc       = 0;
    hold_v    = 1'b0;
    hold_z    = '0;
    hold_n    = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    var_x     = '0;
    var_y     = '0;
    covar_xy  = '0;
    dfdx      = '0;
    dfdy      = '0;

    idle(3);
    check("rst_out_valid", out_valid, 0);
    check("rst_var_z", var_z, 0);
    check("rst_neg_flag", neg_flag, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    idle(1);

    // Directed vector and latency.
    e.z = 37;
    e.n = 1'b0;
    send(16'd4, 16'd9, 16'hFFFD, 16'd2, 16'hFFFF, e);
    in_valid = 1'b0;
    lat = 1;
    t   = 0;
    forever begin
      @(negedge clk);
      if (out_valid || t > 20) break;
      @(posedge clk);
      lat++;
      t++;
    end
    check("latency", lat, 4);
    idle(6);

    // Most-negative gradient magnitude.
    e.z = 50'h3FFF_C000_0000;
    e.n = 1'b0;
    send(16'hFFFF, 16'd0, 16'd0, 16'h8000, 16'd0, e);
    in_valid = 1'b0;

    // Negative sum.
    neg2 = 64'hFFFF_FFFF_FFFF_FFFE;
`ifdef UPE_CLAMP_EN
    e.z = '0;
`else
    e.z = neg2[OW-1:0];
`endif
    e.n = 1'b1;
    send(16'd0, 16'd0, 16'd1, 16'd1, 16'hFFFF, e);
    in_valid = 1'b0;
    idle(8);
    check("drain_directed", sb.size(), 0);

    // Stall with 8 vectors.
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        in_valid = 1'b0;
      end
      begin
        idle(2);
        out_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_inflight", sb.size(), 4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(12);
    check("drain_stall", sb.size(), 0);

    // Back-to-back streaming.
    fork
      begin
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_rand();
        in_valid = 1'b0;
        check("in_rate", cyc - t0, 16);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        run = 0;
        while (out_valid && run < 100) begin
          run++;
          @(negedge clk);
        end
        check("burst_len", run, 16);
      end
    join
    idle(8);
    check("drain_stream", sb.size(), 0);

    // Reset with three in flight.
    for (int i = 0; i < 3; i++) send_rand();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_var_z", var_z, 0);
    check("mid_rst_neg_flag", neg_flag, 0);
    sb.delete();
    idle(2);
    rst_n = 1'b1;
    idle(10);
    e.z = 37;
    e.n = 1'b0;
    send(16'd4, 16'd9, 16'hFFFD, 16'd2, 16'hFFFF, e);
    in_valid = 1'b0;
    idle(8);
    check("drain_post_rst", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
